// File: rtl/led_pattern_scheduler_if.sv
// rtl/led_pattern_scheduler_if.sv - pattern request handshake between a key/control block and the LED scheduler
interface led_pattern_scheduler_if;
  logic       Req_Valid;
  logic [1:0] Req_Mode;
  logic       Req_Ready;

  modport master (
    output Req_Valid,
    output Req_Mode,
    input  Req_Ready
  );

  modport slave (
    input  Req_Valid,
    input  Req_Mode,
    output Req_Ready
  );
endinterface

// File: rtl/led_pattern_scheduler.sv
// rtl/led_pattern_scheduler.sv - 4-LED pattern sequencer with tick time base
// Pattern changes are deferred to the next tick so the LEDs never glitch mid-period.
module led_pattern_scheduler #(
  parameter int unsigned      CNT_W  = 26,
  parameter logic [CNT_W-1:0] T_TICK = CNT_W'(49_999_999)
) (
  input  logic                   CLK,
  input  logic                   RST,
  led_pattern_scheduler_if.slave req_if,
  output logic [3:0]             LED_Out,
  output logic [1:0]             Mode_Out,
  output logic                   Tick_Out
);

  localparam logic [1:0] M_OFF      = 2'd0;
  localparam logic [1:0] M_FLASH    = 2'd1;
  localparam logic [1:0] M_RUN      = 2'd2;
  localparam logic [1:0] M_PINGPONG = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       pend_mode_q;
  logic [1:0]       mode_q;
  logic [3:0]       led_q;
  logic [3:0]       led_d;
  logic             dir_q;
  logic             dir_d;

  logic             tick;
  logic             accept;
  logic             ready;

  function automatic logic [3:0] init_pattern(input logic [1:0] mode);
    logic [3:0] pat;
    case (mode)
      M_OFF:      pat = 4'b0000;
      M_FLASH:    pat = 4'b1111;
      M_RUN:      pat = 4'b0001;
      M_PINGPONG: pat = 4'b0001;
      default:    pat = 4'b0000;
    endcase
    return pat;
  endfunction

  assign tick   = (cnt_q == T_TICK);
  assign ready  = (state_q == ST_IDLE);
  assign accept = req_if.Req_Valid && ready;

  assign req_if.Req_Ready = ready;
  assign Tick_Out         = tick;
  assign LED_Out          = led_q;
  assign Mode_Out         = mode_q;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Next LED value and direction for a normal (non-applying) tick.
  always_comb begin
    led_d = led_q;
    dir_d = dir_q;
    case (mode_q)
      M_OFF:   led_d = 4'b0000;
      M_FLASH: led_d = ~led_q;
      M_RUN:   led_d = {led_q[2:0], led_q[3]};
      M_PINGPONG: begin
        if (dir_q == DIR_LEFT) begin
          if (led_q[3]) begin
            dir_d = DIR_RIGHT;
            led_d = 4'b0100;
          end else begin
            led_d = {led_q[2:0], 1'b0};
          end
        end else begin
          if (led_q[0]) begin
            dir_d = DIR_LEFT;
            led_d = 4'b0010;
          end else begin
            led_d = {1'b0, led_q[3:1]};
          end
        end
      end
      default: led_d = led_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      pend_mode_q <= M_OFF;
      mode_q      <= M_OFF;
      led_q       <= 4'b0000;
      dir_q       <= DIR_LEFT;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            led_q <= led_d;
            dir_q <= dir_d;
          end
          // A request accepted on the tick edge waits for the following tick.
          if (accept) begin
            pend_mode_q <= req_if.Req_Mode;
            state_q     <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (tick) begin
            mode_q  <= pend_mode_q;
            led_q   <= init_pattern(pend_mode_q);
            dir_q   <= DIR_LEFT;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// tb/tb_led_pattern_scheduler.sv - scoreboard bench for led_pattern_scheduler with T_TICK=3
module tb_led_pattern_scheduler;

  typedef struct {
    int         cyc;
    logic       ready;
    logic       tick;
    logic [3:0] led;
    logic [1:0] mode;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] led_out;
  logic [1:0] mode_out;
  logic       tick_out;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  exp_t exp_q[$];

  // Reference model: pattern expressed as (mode, steps since applied).
  int         m_cnt   = 0;
  logic [1:0] m_mode  = 2'd0;
  int         m_step  = 0;
  bit         m_pend  = 0;
  logic [1:0] m_pmode = 2'd0;

  logic [3:0] pp_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

  led_pattern_scheduler_if req_bus ();

  led_pattern_scheduler #(
    .CNT_W  (26),
    .T_TICK (26'd3)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .req_if   (req_bus.slave),
    .LED_Out  (led_out),
    .Mode_Out (mode_out),
    .Tick_Out (tick_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_led(input logic [1:0] mode, input int step);
    case (mode)
      2'd1:    return (step % 2 == 0) ? 4'b1111 : 4'b0000;
      2'd2:    return 4'(1 << (step % 4));
      2'd3:    return pp_seq[step % 6];
      default: return 4'b0000;
    endcase
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [1:0] md);
    exp_t e;
    bit   tk;
    bit   acc;
    rst               = r;
    req_bus.Req_Valid = v;
    req_bus.Req_Mode  = md;
    if (r) begin
      m_cnt  = 0;
      m_mode = 2'd0;
      m_step = 0;
      m_pend = 0;
    end else begin
      tk  = (m_cnt == 3);
      acc = v && !m_pend;
      if (tk) begin
        m_cnt = 0;
        if (m_pend) begin
          m_mode = m_pmode;
          m_step = 0;
          m_pend = 0;
        end else begin
          m_step = m_step + 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (acc) begin
        m_pend  = 1;
        m_pmode = md;
      end
    end
    e.cyc   = cyc_n;
    e.ready = !m_pend;
    e.tick  = (m_cnt == 3);
    e.led   = model_led(m_mode, m_step);
    e.mode  = m_mode;
    exp_q.push_back(e);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (led_out !== e.led) begin
          errors++;
          $display("FAIL led cyc=%0d got=%b exp=%b", e.cyc, led_out, e.led);
        end
        checks++;
        if (mode_out !== e.mode) begin
          errors++;
          $display("FAIL mode cyc=%0d got=%0d exp=%0d", e.cyc, mode_out, e.mode);
        end
        checks++;
        if (req_bus.Req_Ready !== e.ready) begin
          errors++;
          $display("FAIL ready cyc=%0d got=%b exp=%b", e.cyc, req_bus.Req_Ready, e.ready);
        end
        checks++;
        if (tick_out !== e.tick) begin
          errors++;
          $display("FAIL tick cyc=%0d got=%b exp=%b", e.cyc, tick_out, e.tick);
        end
      end
    end
  end

  initial begin : stimulus
    cyc(1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 2'd0);
    idle(8);
    cyc(1'b0, 1'b1, 2'd2);
    idle(22);
    cyc(1'b0, 1'b1, 2'd1);
    idle(18);
    cyc(1'b0, 1'b1, 2'd3);
    idle(36);
    cyc(1'b0, 1'b1, 2'd2);
    idle(14);
    cyc(1'b0, 1'b1, 2'd0);
    idle(8);
    cyc(1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 2'd1);
    idle(10);
    cyc(1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 2'd0);
    idle(10);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 149) == 0),
          ($urandom_range(0, 5) == 0),
          2'($urandom_range(0, 3)));
    end
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
